mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates a single-port unified 16-bit memory between the instruction-fetch stage (read-only) and the data-memory stage (LW/LB/SW/SV accesses) of the pipelined processor. Each access is sequenced through a small FSM that holds the memory interface stable until the memory signals ready. The arbiter produces per-requester stall signals consumed by the pipeline registers and the hazard logic. It also extracts and extends byte loads, and bounds every access with a timeout.

## Interface
- `TIMEOUT`, 255: max cycles waiting for `mem_ready` before forced completion; 0 disables.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request, held until `if_valid`.
- `if_addr` in 16: fetch byte address; bit 0 ignored.
- `if_rdata` out 16: fetched word, valid with `if_valid`.
- `if_valid` out 1: one-cycle completion pulse for fetch.
- `if_stall` out 1: `if_req && !if_valid`.
- `dm_rd`, `dm_wr` in 1: data read/write request, held until `dm_valid`.
- `dm_addr` in 16: data byte address.
- `dm_wdata` in 16: store data.
- `dm_size` in 2: 00 word, 01 byte zero-extend, 10 byte sign-extend; 11 treated as 00.
- `dm_rdata` out 16: load result, valid with `dm_valid`.
- `dm_valid` out 1: one-cycle completion pulse for data.
- `dm_stall` out 1: `(dm_rd||dm_wr) && !dm_valid`.
- `mem_en` out 1: memory access enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 16: byte address, `mem_addr[0]` always 0.
- `mem_wdata` out 16: write data.
- `mem_be` out 2: byte enables, bit 0 = low lane (even byte).
- `mem_rdata` in 16: read data, sampled with `mem_ready`.
- `mem_ready` in 1: access complete.
- `err` out 1: sticky timeout flag, cleared only by reset.

## Operation
- **States:** IDLE, DM_ACC, IF_ACC, DONE.
- **IDLE arbitration:**
  - Data request only: go to DM_ACC.
  - Fetch request only: go to IF_ACC.
  - Both pending: grant the requester not served last. `last_grant` resets to IF, so the first conflict goes to data.
  - Neither pending: stay in IDLE.
- **On entering an ACC state:** register `mem_addr`, `mem_we`, `mem_be`, `mem_wdata` and the size/kind; assert `mem_en`. All of these stay stable until exit from ACC.
- **Fetch:** `mem_we`=0, `mem_be`=11.
- **Word data access:** `mem_be`=11; `mem_wdata`=`dm_wdata`.
- **Byte data access:**
  - `mem_be` = 01 if `dm_addr[0]`=0, else 10.
  - Write replicates `dm_wdata[7:0]` into both lanes.
  - Read selects lane `dm_addr[0]`, then zero- or sign-extends to 16 bits per `dm_size`.
- **`dm_rd` and `dm_wr` both high:** write wins.
- **ACC exit:**
  - On an edge sampling `mem_ready`=1: capture `mem_rdata` (processed) into the requester's rdata register, go to DONE, update `last_grant`.
  - On timeout: if the wait counter reaches `TIMEOUT` without ready, go to DONE with rdata=0 and set `err`.
- **DONE:** `mem_en`=0; the served requester's valid=1 for exactly this cycle; next state IDLE unconditionally. DONE is the requester's advance cycle; a request still high in the following IDLE is treated as new.
- **Reset (async):** state IDLE. `mem_en`, `mem_we`, `mem_be`, `if_valid`, `dm_valid`, `err`, wait counter = 0. `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0. `last_grant`=IF.
- **Reset mid-access:** `mem_en` drops immediately and the access is abandoned. No valid pulse is generated.

## Timing
- Request presented in cycle N (IDLE) → `mem_en` high from cycle N+1.
- Ready sampled at the end of cycle N+k (k≥1) → valid high in cycle N+k+1.
- Minimum latency with `mem_ready` tied 1: valid 2 cycles after request. Throughput: 3 cycles per access.
- Wait counter: 8-bit, cleared on ACC entry, increments each ACC cycle without ready. Timeout fires when the counter equals `TIMEOUT` (nonzero).
- Stalls are combinational from registered valid and the request inputs; no path runs from `mem_ready` to the stalls.
- `mem_rdata` is ignored except at the ready edge.
- `mem_ready` outside ACC is ignored.

## Test plan
- **Fetch, ready tied 1:** `if_req`=1, `if_addr`=0x0010, mem returns 0xA5C3 → `mem_en` cycle N+1 with `mem_addr`=0x0010, `mem_be`=11; `if_valid`=1 and `if_rdata`=0xA5C3 in N+2; `if_stall` high N..N+1.
- **Byte loads, ready tied 1:** `dm_rd`, `dm_addr`=0x0021, `dm_size`=10, mem returns 0x80FF → `mem_be`=10, `dm_rdata`=0xFF80. Repeat with `dm_size`=01 → 0x0080.
- **Byte store:** `dm_wr`, `dm_addr`=0x0004, `dm_size`=01, `dm_wdata`=0x1234 → `mem_we`=1, `mem_be`=01, `mem_wdata`=0x3434, `dm_valid` one cycle.
- **Conflict:** `if_req` and `dm_rd` held continuously, ready tied 1 → grants alternate DM, IF, DM, IF, with each valid pulse 3 cycles apart.
- **Timeout:** `TIMEOUT`=4, `mem_ready`=0 → `mem_en` high 5 cycles, then valid with rdata=0 and `err`=1, and `err` stays 1 after later accesses.
- **Reset mid-access:** drop `rst_n` during DM_ACC → `mem_en`/`mem_we` go 0 asynchronously, no `dm_valid`. After release, held `dm_rd` restarts the access from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data memory stages.
// Each access runs IDLE -> ACC -> DONE; byte loads are lane-selected and extended here.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    input  logic [1:0]  dm_size,
    output logic [15:0] dm_rdata,
    output logic        dm_valid,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        err
);
    // state  | meaning
    // IDLE   | no access in flight, arbitrate pending requests
    // DM_ACC | data access presented to memory, waiting for ready/timeout
    // IF_ACC | fetch access presented to memory, waiting for ready/timeout
    // DONE   | valid pulse to the served requester, memory idle
    typedef enum logic [1:0] {IDLE, DM_ACC, IF_ACC, DONE} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam bit         TIMEOUT_EN  = (TIMEOUT != 0);

    state_t      state, state_nxt;
    logic        grant_dm, grant_if;
    logic        last_dm;
    logic        byte_acc, sign_ext, lane;
    logic [7:0]  wait_cnt;
    logic        dm_req, in_acc, timeout_hit, acc_exit, dm_byte;
    logic [7:0]  rd_byte;
    logic [15:0] ld_data;

    assign dm_req      = dm_rd | dm_wr;
    assign in_acc      = (state == DM_ACC) || (state == IF_ACC);
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == TIMEOUT_CNT);
    assign acc_exit    = in_acc && (mem_ready || timeout_hit);
    assign dm_byte     = dm_size[0] ^ dm_size[1];

    assign rd_byte = lane ? mem_rdata[15:8] : mem_rdata[7:0];
    assign ld_data = !byte_acc ? mem_rdata :
                     sign_ext  ? {{8{rd_byte[7]}}, rd_byte} : {8'h00, rd_byte};

    assign if_stall = if_req && !if_valid;
    assign dm_stall = dm_req && !dm_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                // On conflict, serve whoever was not served last
                if (dm_req && (!if_req || !last_dm)) begin
                    state_nxt = DM_ACC;
                    grant_dm  = 1'b1;
                end else if (if_req) begin
                    state_nxt = IF_ACC;
                    grant_if  = 1'b1;
                end
            end
            DM_ACC, IF_ACC: if (mem_ready || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 2'b00;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
            if_rdata  <= 16'h0000;
            dm_rdata  <= 16'h0000;
            err       <= 1'b0;
            wait_cnt  <= 8'h00;
            last_dm   <= 1'b0;
            byte_acc  <= 1'b0;
            sign_ext  <= 1'b0;
            lane      <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            if (grant_dm) begin
                mem_en    <= 1'b1;
                mem_we    <= dm_wr;
                mem_addr  <= dm_addr & 16'hFFFE;
                mem_be    <= dm_byte ? (dm_addr[0] ? 2'b10 : 2'b01) : 2'b11;
                mem_wdata <= dm_byte ? {2{dm_wdata[7:0]}} : dm_wdata;
                byte_acc  <= dm_byte;
                sign_ext  <= (dm_size == 2'b10);
                lane      <= dm_addr[0];
                wait_cnt  <= 8'h00;
            end else if (grant_if) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= if_addr & 16'hFFFE;
                mem_be   <= 2'b11;
                byte_acc <= 1'b0;
                sign_ext <= 1'b0;
                lane     <= 1'b0;
                wait_cnt <= 8'h00;
            end else if (acc_exit) begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
                // Ready wins over a timeout landing on the same edge
                if (!mem_ready) err <= 1'b1;
                if (state == DM_ACC) begin
                    dm_valid <= 1'b1;
                    dm_rdata <= mem_ready ? ld_data : 16'h0000;
                    last_dm  <= 1'b1;
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= mem_ready ? ld_data : 16'h0000;
                    last_dm  <= 1'b0;
                end
            end else if (in_acc) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level model.
// The model predicts latency, memory-side fields and load results from the access rules.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_valid, if_stall;
    logic        dm_rd, dm_wr;
    logic [15:0] dm_addr, dm_wdata;
    logic [1:0]  dm_size;
    logic [15:0] dm_rdata;
    logic        dm_valid, dm_stall;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [1:0]  mem_be;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    localparam int TO = 4;

    mem_port_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_size(dm_size), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    function automatic bit is_byte(input logic [1:0] s);
        return (s == 2'd1) || (s == 2'd2);
    endfunction

    function automatic logic [15:0] exp_load(input logic [15:0] m, input logic [15:0] a,
                                             input logic [1:0] s);
        int b;
        if (!is_byte(s)) return m;
        b = (a % 2 == 1) ? int'(m) / 256 : int'(m) % 256;
        if (s == 2'd2 && b >= 128) b = b + 65280;
        return 16'(b);
    endfunction

    function automatic logic [1:0] exp_be(input logic [15:0] a, input logic [1:0] s);
        if (!is_byte(s)) return 2'd3;
        return (a % 2 == 1) ? 2'd2 : 2'd1;
    endfunction

    function automatic logic [15:0] exp_wdata(input logic [15:0] w, input logic [1:0] s);
        if (!is_byte(s)) return w;
        return 16'((int'(w) % 256) * 257);
    endfunction

    // Drives one request from IDLE, models memory with `delay` not-ready cycles,
    // and reports what the DUT did. Returns in an IDLE cycle.
    task automatic run_access(input bit is_if, input bit rd, input bit wr,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [1:0] size, input int delay, input logic [15:0] mdata,
                              output int lat, output int en_first, output int en_cyc,
                              output logic [15:0] c_addr, output logic [15:0] c_wdata,
                              output logic [1:0] c_be, output logic c_we,
                              output logic [15:0] rdata, output bit stray, output bit stall_bad);
        bit seen = 0;
        lat = -1; en_first = -1; en_cyc = 0; stray = 0; stall_bad = 0;
        c_addr = 16'h0; c_wdata = 16'h0; c_be = 2'b0; c_we = 1'b0; rdata = 16'h0;
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            dm_rd = rd; dm_wr = wr; dm_addr = addr; dm_wdata = wdata; dm_size = size;
        end
        mem_ready = 1'b0;
        mem_rdata = 16'($urandom);
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            #1;
            if ((is_if ? if_stall : dm_stall) !== 1'b1) stall_bad = 1;
            @(negedge clk);
            if ((is_if ? dm_valid : if_valid) === 1'b1) stray = 1;
            if ((is_if ? if_valid : dm_valid) === 1'b1) begin
                lat = c;
                rdata = is_if ? if_rdata : dm_rdata;
                if (mem_en !== 1'b0) stall_bad = 1;
                #1;
                if ((is_if ? if_stall : dm_stall) !== 1'b0) stall_bad = 1;
            end else if (mem_en === 1'b1) begin
                if (!seen) begin
                    en_first = c; c_addr = mem_addr; c_wdata = mem_wdata;
                    c_be = mem_be; c_we = mem_we;
                end
                seen = 1;
                en_cyc++;
                if (en_cyc > delay) begin
                    mem_ready = 1'b1; mem_rdata = mdata;
                end else begin
                    mem_ready = 1'b0; mem_rdata = 16'($urandom);
                end
            end else begin
                mem_ready = 1'b0; mem_rdata = 16'($urandom);
            end
        end
        if_req = 1'b0; dm_rd = 1'b0; dm_wr = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 16'h0; dm_rd = 1'b0; dm_wr = 1'b0;
        dm_addr = 16'h0; dm_wdata = 16'h0; dm_size = 2'b0;
        mem_rdata = 16'h0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_be, if_valid, dm_valid, err} !== 7'b0)
            $display("FAIL reset_ctrl: got %b want 0000000", {mem_en, mem_we, mem_be, if_valid, dm_valid, err});
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 64'h0)
            $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        else n_pass++;
        if_req = 1'b1;
        #1;
        n_checks++;
        if (if_stall !== 1'b1) $display("FAIL reset_if_stall: got %b want 1", if_stall);
        else n_pass++;
        if_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int lat, ef, ec; logic [15:0] a, w, r; logic [1:0] be; logic we; bit st, sb;
        run_access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, 2'b0, 0, 16'hA5C3,
                   lat, ef, ec, a, w, be, we, r, st, sb);
        n_checks++;
        if (ef !== 1 || ec !== 1 || lat !== 2)
            $display("FAIL fetch_timing: en_first=%0d en_cycles=%0d valid_at=%0d want 1 1 2", ef, ec, lat);
        else n_pass++;
        n_checks++;
        if (a !== 16'h0010 || be !== 2'b11 || we !== 1'b0)
            $display("FAIL fetch_mem: addr=%h be=%b we=%b want 0010 11 0", a, be, we);
        else n_pass++;
        n_checks++;
        if (r !== 16'hA5C3 || st || sb)
            $display("FAIL fetch_data: rdata=%h stray=%b stall_bad=%b want a5c3 0 0", r, st, sb);
        else n_pass++;
    endtask

    task automatic test_byte_ops();
        int lat, ef, ec; logic [15:0] a, w, r; logic [1:0] be; logic we; bit st, sb;
        run_access(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0, 2'b10, 0, 16'h80FF,
                   lat, ef, ec, a, w, be, we, r, st, sb);
        n_checks++;
        if (be !== 2'b10 || a !== 16'h0020 || r !== 16'hFF80 || lat !== 2)
            $display("FAIL lb_sign: be=%b addr=%h rdata=%h lat=%0d want 10 0020 ff80 2", be, a, r, lat);
        else n_pass++;
        run_access(1'b0, 1'b1, 1'b0, 16'h0021, 16'h0, 2'b01, 0, 16'h80FF,
                   lat, ef, ec, a, w, be, we, r, st, sb);
        n_checks++;
        if (be !== 2'b10 || r !== 16'h0080)
            $display("FAIL lb_zero: be=%b rdata=%h want 10 0080", be, r);
        else n_pass++;
        run_access(1'b0, 1'b0, 1'b1, 16'h0004, 16'h1234, 2'b01, 0, 16'h0,
                   lat, ef, ec, a, w, be, we, r, st, sb);
        n_checks++;
        if (we !== 1'b1 || be !== 2'b01 || w !== 16'h3434 || lat !== 2 || st || sb)
            $display("FAIL sb_store: we=%b be=%b wdata=%h lat=%0d stray=%b want 1 01 3434 2 0",
                     we, be, w, lat, st);
        else n_pass++;
    endtask

    task automatic test_conflict();
        int q_cyc[$]; bit q_dm[$];
        bit last_dm_m = 0;
        test_reset();
        if_req = 1'b1; if_addr = 16'h0100; dm_rd = 1'b1; dm_addr = 16'h0200; dm_size = 2'b00;
        mem_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            mem_rdata = 16'($urandom);
            @(negedge clk);
            if (if_valid === 1'b1) begin q_cyc.push_back(c); q_dm.push_back(1'b0); end
            if (dm_valid === 1'b1) begin q_cyc.push_back(c); q_dm.push_back(1'b1); end
        end
        if_req = 1'b0; dm_rd = 1'b0; mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (q_cyc.size() !== 4) $display("FAIL conflict_count: got %0d pulses want 4", q_cyc.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < q_cyc.size(); i++) begin
            last_dm_m = !last_dm_m;
            n_checks++;
            if (q_cyc[i] !== 2 + 3 * i || q_dm[i] !== last_dm_m)
                $display("FAIL conflict_grant%0d: cycle=%0d dm=%b want cycle=%0d dm=%b",
                         i, q_cyc[i], q_dm[i], 2 + 3 * i, last_dm_m);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int lat, ef, ec, d, kind; logic [15:0] a, w, r, addr, wd, md; logic [1:0] be, sz;
        logic we; bit st, sb, is_if, rd, wr;
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 3));
            is_if = (kind == 0); rd = (kind == 1 || kind == 3); wr = (kind >= 2);
            addr = 16'($urandom); wd = 16'($urandom); md = 16'($urandom);
            sz = 2'($urandom); d = int'($urandom_range(0, TO - 1));
            run_access(is_if, rd, wr, addr, wd, sz, d, md, lat, ef, ec, a, w, be, we, r, st, sb);
            if (is_if) sz = 2'b00;
            n_checks++;
            if (lat !== d + 2 || ef !== 1 || ec !== d + 1 || st || sb)
                $display("FAIL rnd%0d_timing: lat=%0d en_first=%0d en=%0d stray=%b stall_bad=%b want %0d 1 %0d 0 0",
                         i, lat, ef, ec, st, sb, d + 2, d + 1);
            else n_pass++;
            n_checks++;
            if (a !== (addr & 16'hFFFE) || be !== exp_be(addr, sz) || we !== wr)
                $display("FAIL rnd%0d_mem: addr=%h be=%b we=%b want %h %b %b",
                         i, a, be, we, addr & 16'hFFFE, exp_be(addr, sz), wr);
            else n_pass++;
            n_checks++;
            if (wr ? (w !== exp_wdata(wd, sz)) : (r !== exp_load(md, addr, sz)))
                $display("FAIL rnd%0d_data: wdata=%h rdata=%h want wdata=%h rdata=%h (wr=%b)",
                         i, w, r, exp_wdata(wd, sz), exp_load(md, addr, sz), wr);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int lat, ef, ec; logic [15:0] a, w, r; logic [1:0] be; logic we; bit st, sb;
        n_checks++;
        if (err !== 1'b0) $display("FAIL err_before_timeout: got %b want 0", err);
        else n_pass++;
        run_access(1'b0, 1'b1, 1'b0, 16'h0300, 16'h0, 2'b00, 1000, 16'hBEEF,
                   lat, ef, ec, a, w, be, we, r, st, sb);
        n_checks++;
        if (ec !== TO + 1 || lat !== TO + 2 || r !== 16'h0 || err !== 1'b1)
            $display("FAIL timeout: en=%0d lat=%0d rdata=%h err=%b want %0d %0d 0000 1",
                     ec, lat, r, err, TO + 1, TO + 2);
        else n_pass++;
        run_access(1'b1, 1'b0, 1'b0, 16'h0042, 16'h0, 2'b00, 2, 16'h5A5A,
                   lat, ef, ec, a, w, be, we, r, st, sb);
        n_checks++;
        if (err !== 1'b1 || r !== 16'h5A5A || lat !== 4)
            $display("FAIL err_sticky: err=%b rdata=%h lat=%0d want 1 5a5a 4", err, r, lat);
        else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        bit bad_valid = 0;
        dm_wr = 1'b1; dm_addr = 16'h0500; dm_wdata = 16'hCAFE; dm_size = 2'b00; mem_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1)
            $display("FAIL mid_acc_started: en=%b we=%b want 1 1", mem_en, mem_we);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || err !== 1'b0)
            $display("FAIL mid_acc_async: en=%b we=%b err=%b want 0 0 0", mem_en, mem_we, err);
        else n_pass++;
        repeat (3) begin
            @(negedge clk);
            if (dm_valid !== 1'b0) bad_valid = 1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bad_valid || mem_en !== 1'b1 || mem_addr !== 16'h0500)
            $display("FAIL mid_acc_restart: stray_valid=%b en=%b addr=%h want 0 1 0500",
                     bad_valid, mem_en, mem_addr);
        else n_pass++;
        mem_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dm_valid !== 1'b1) $display("FAIL mid_acc_complete: dm_valid=%b want 1", dm_valid);
        else n_pass++;
        dm_wr = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_byte_ops();
        test_conflict();
        test_random();
        test_timeout();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
